// File: rtl/mcpu_alu_ctrl_if.sv
// Instruction, register-file and ALU signal bundle for mcpu_alu_ctrl.
// The slave side is the controller; the master side is whatever drives
// instructions, loads the register file and hosts the ALU itself.
interface mcpu_alu_ctrl_if #(
  parameter int CMD_SIZE  = 3,
  parameter int WORD_SIZE = 16
);
  logic                 instr_valid;
  logic                 instr_ready;
  logic [CMD_SIZE-1:0]  op;
  logic [1:0]           rd;
  logic [1:0]           rs1;
  logic [1:0]           rs2;
  logic                 wr_en;
  logic [1:0]           wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic [1:0]           rd_addr;
  logic [WORD_SIZE-1:0] rd_data;
  logic [CMD_SIZE-1:0]  alu_cmd;
  logic [WORD_SIZE-1:0] alu_in1;
  logic [WORD_SIZE-1:0] alu_in2;
  logic [WORD_SIZE-1:0] alu_out;
  logic                 alu_cf;
  logic                 done;
  logic [WORD_SIZE-1:0] result;
  logic                 cf;

  modport master (
    output instr_valid, op, rd, rs1, rs2, wr_en, wr_addr, wr_data, rd_addr,
           alu_out, alu_cf,
    input  instr_ready, rd_data, alu_cmd, alu_in1, alu_in2, done, result, cf
  );

  modport slave (
    input  instr_valid, op, rd, rs1, rs2, wr_en, wr_addr, wr_data, rd_addr,
           alu_out, alu_cf,
    output instr_ready, rd_data, alu_cmd, alu_in1, alu_in2, done, result, cf
  );
endinterface

// File: rtl/mcpu_alu_ctrl.sv
// Sequencer for an external multi-cycle ALU with a 4-entry register file.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | ready for an instruction; external register writes allowed
//   EXEC  | drive captured command/operands to the ALU, arm settle timer
//   WAIT  | ALU settling, ALU_WAIT cycles (down-counter to terminal count)
//   WB    | done pulse; result written to r[rd] and result at exit edge
//
// ALU_WAIT must lie in 1..15; the settle timer is four bits wide.
module mcpu_alu_ctrl #(
  parameter int CMD_SIZE  = 3,
  parameter int WORD_SIZE = 16,
  parameter int ALU_WAIT  = 1
) (
  input logic              clk,
  input logic              reset,
  mcpu_alu_ctrl_if.slave   bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]           state;
  logic [3:0]           wait_cnt;
  logic [WORD_SIZE-1:0] regs [4];

  logic [CMD_SIZE-1:0]  op_q;
  logic [1:0]           rd_q;
  logic [WORD_SIZE-1:0] opa_q;
  logic [WORD_SIZE-1:0] opb_q;

  logic [CMD_SIZE-1:0]  alu_cmd_q;
  logic [WORD_SIZE-1:0] alu_in1_q;
  logic [WORD_SIZE-1:0] alu_in2_q;
  logic [WORD_SIZE-1:0] result_q;
  logic                 cf_q;

  logic accept;
  logic carry_op;

  assign accept   = bus.instr_valid && (state == S_IDLE);
  // ADD and the two codes the ALU also treats as ADD update the carry flag.
  assign carry_op = (op_q == CMD_SIZE'(3)) || (op_q == CMD_SIZE'(6)) ||
                    (op_q == CMD_SIZE'(7));

  // Sequencer state and ALU settle down-counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      case (state)
        S_IDLE: if (accept) state <= S_EXEC;
        S_EXEC: begin
          state    <= S_WAIT;
          wait_cnt <= 4'(ALU_WAIT);
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) state <= S_WB;
        end
        S_WB:    state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Capture the instruction and its operands (pre-write values) at acceptance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q  <= '0;
      rd_q  <= '0;
      opa_q <= '0;
      opb_q <= '0;
    end else if (accept) begin
      op_q  <= bus.op;
      rd_q  <= bus.rd;
      opa_q <= regs[bus.rs1];
      opb_q <= regs[bus.rs2];
    end
  end

  // ALU drive registers; loaded leaving EXEC and held until the next EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_cmd_q <= '0;
      alu_in1_q <= '0;
      alu_in2_q <= '0;
    end else if (state == S_EXEC) begin
      alu_cmd_q <= op_q;
      alu_in1_q <= opa_q;
      alu_in2_q <= opb_q;
    end
  end

  // Register file, result and carry: write-back in WB, external load in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) regs[i] <= '0;
      result_q <= '0;
      cf_q     <= 1'b0;
    end else if (state == S_WB) begin
      regs[rd_q] <= bus.alu_out;
      result_q   <= bus.alu_out;
      if (carry_op) cf_q <= bus.alu_cf;
    end else if ((state == S_IDLE) && bus.wr_en) begin
      regs[bus.wr_addr] <= bus.wr_data;
    end
  end

  assign bus.instr_ready = (state == S_IDLE);
  assign bus.done        = (state == S_WB);
  assign bus.rd_data     = regs[bus.rd_addr];
  assign bus.alu_cmd     = alu_cmd_q;
  assign bus.alu_in1     = alu_in1_q;
  assign bus.alu_in2     = alu_in2_q;
  assign bus.result      = result_q;
  assign bus.cf          = cf_q;

endmodule
